// File: rtl/video_line_fetcher_pkg.sv
// Shared definitions for the video line fetcher.
//   fetch_state_t      : fetch FSM state encoding
//   VIDEO_WORD_ADDR_W  : width of the in-bank SDRAM word address
//   pack_word_addr()   : builds the 21-bit SDRAM word address {5'b0, bank, word}
package video_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      FLUSH = 2'd3
   } fetch_state_t;

   localparam int VIDEO_WORD_ADDR_W = 15;
   localparam int MEM_ADDR_W        = 21;

   // word_addr is the Apple byte address with bit 0 already dropped
   function automatic logic [MEM_ADDR_W-1:0] pack_word_addr(
      input logic                         bank,
      input logic [VIDEO_WORD_ADDR_W-1:0] word_addr
   );
      return {5'b0, bank, word_addr};
   endfunction

endpackage

// File: rtl/video_line_fetcher_sync_fifo_flush.sv
// Synchronous FIFO with single-cycle flush and registered first-word-fall-through
// output. The head entry is held in dout/valid registers, so a word pushed into an
// empty FIFO is visible on the cycle after the push.
//   clk, reset : clock and synchronous active-high reset
//   flush      : empty the FIFO this cycle (wins over push/pop)
//   push, din  : write a word
//   pop        : consume the head word (ignored when valid is low)
//   dout, valid: head word and its presence
//   count      : current occupancy
module sync_fifo_flush #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr_nx;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    cnt_after_pop;
   logic [CW-1:0]    count_nx;
   logic             valid_q;
   logic [WIDTH-1:0] dout_q;
   logic             do_pop;
   logic             do_push;

   always_comb begin
      do_pop        = pop && valid_q;
      do_push       = push && ((count_q != CW'(DEPTH)) || do_pop);
      cnt_after_pop = count_q - CW'(do_pop);
      count_nx      = cnt_after_pop + CW'(do_push);
      rd_ptr_nx     = rd_ptr + AW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         dout_q  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr  <= rd_ptr_nx;
         count_q <= count_nx;
         valid_q <= (count_nx != '0);
         // The new head is either the incoming word (FIFO drained) or the
         // entry already stored behind the popped one.
         if (cnt_after_pop == '0) begin
            if (do_push)
               dout_q <= din;
         end else begin
            dout_q <= mem[rd_ptr_nx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !reset && !flush)
         mem[wr_ptr] <= din;
   end

   assign dout  = dout_q;
   assign valid = valid_q;
   assign count = count_q;

endmodule

// File: rtl/video_line_fetcher.sv
// Fetches one scanline of shadow video memory from the SDRAM video port and
// streams the 32-bit words (two Apple bytes, main/aux interleaved) to the renderer.
//   clk_logic, reset         : clock, synchronous active-high reset
//   line_start_i             : start a line fetch (aborts any fetch in progress)
//   base_addr_i, bank_i      : Apple byte address of the line and SDRAM bank
//   count_i                  : words to fetch, 0..MAX_WORDS
//   mem_rd_o, mem_addr_o     : read request and word address to the SDRAM port
//   mem_ready_i              : request accepted this cycle
//   mem_valid_i, mem_q_i     : returned read data
//   out_valid_o/ready_i      : output stream handshake
//   out_data_o, out_last_o   : fetched word and end-of-line marker
//   busy_o                   : fetch in progress or words still buffered
//
// state | meaning
// IDLE  | no fetch active
// REQ   | mem_rd_o high until accepted, or mem_rd_o low waiting for FIFO room
// WAIT  | request accepted, waiting for its data
// FLUSH | request of an aborted line outstanding; its data will be dropped
module video_line_fetcher #(
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_WORDS  = 64,
   localparam int CNT_W = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk_logic,
   input  logic             reset,
   input  logic             line_start_i,
   input  logic [15:0]      base_addr_i,
   input  logic             bank_i,
   input  logic [CNT_W-1:0] count_i,
   output logic             mem_rd_o,
   output logic [20:0]      mem_addr_o,
   input  logic             mem_ready_i,
   input  logic             mem_valid_i,
   input  logic [31:0]      mem_q_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      out_data_o,
   output logic             out_last_o,
   output logic             busy_o
);

   import video_fetch_pkg::*;

   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t                 state;
   logic [VIDEO_WORD_ADDR_W-1:0] cur_addr;
   logic                         cur_bank;
   logic [CNT_W-1:0]             remaining;
   logic                         discard;
   logic                         mem_rd_q;
   logic [20:0]                  mem_addr_q;

   logic [VIDEO_WORD_ADDR_W-1:0] new_addr;
   logic [VIDEO_WORD_ADDR_W-1:0] next_addr;
   logic [VIDEO_WORD_ADDR_W-1:0] sel_addr;
   logic                         sel_bank;
   logic [CNT_W-1:0]             sel_count;
   logic                         push;
   logic                         push_last;
   logic                         pop;
   logic [FCW-1:0]               fifo_count;
   logic [FCW-1:0]               occ_next;
   logic                         room;
   logic [32:0]                  fifo_dout;
   logic                         fifo_valid;
   logic                         unused_base_lsb;

   assign unused_base_lsb = base_addr_i[0];

   always_comb begin
      new_addr  = base_addr_i[15:1];
      next_addr = cur_addr + VIDEO_WORD_ADDR_W'(1);
      // Line parameters in force after this cycle: a line start overrides.
      sel_addr  = line_start_i ? new_addr  : cur_addr;
      sel_bank  = line_start_i ? bank_i    : cur_bank;
      sel_count = line_start_i ? count_i   : remaining;
      // Data arriving together with a line start belongs to the old line.
      push      = (state == WAIT) && mem_valid_i && !line_start_i;
      push_last = (remaining == CNT_W'(1));
      pop       = fifo_valid && out_ready_i;
      // Occupancy as of next cycle; a request is only issued when the word it
      // returns is guaranteed a slot.
      if (line_start_i)
         occ_next = '0;
      else
         occ_next = fifo_count + FCW'(push) - FCW'(pop);
      room = (occ_next < FCW'(FIFO_DEPTH));
   end

   always_ff @(posedge clk_logic) begin
      if (reset) begin
         state      <= IDLE;
         cur_addr   <= '0;
         cur_bank   <= 1'b0;
         remaining  <= '0;
         discard    <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         if (line_start_i) begin
            cur_addr  <= new_addr;
            cur_bank  <= bank_i;
            remaining <= count_i;
         end
         case (state)
            IDLE: begin
               if (line_start_i && (count_i != '0)) begin
                  state      <= REQ;
                  mem_rd_q   <= room;
                  mem_addr_q <= pack_word_addr(bank_i, new_addr);
               end
            end
            REQ: begin
               if (mem_rd_q) begin
                  // A presented request is never withdrawn; an abort only
                  // marks its data for dropping.
                  if (mem_ready_i) begin
                     mem_rd_q <= 1'b0;
                     discard  <= 1'b0;
                     state    <= (discard || line_start_i) ? FLUSH : WAIT;
                  end else if (line_start_i) begin
                     discard <= 1'b1;
                  end
               end else if (line_start_i) begin
                  if (count_i == '0) begin
                     state <= IDLE;
                  end else begin
                     mem_rd_q   <= room;
                     mem_addr_q <= pack_word_addr(bank_i, new_addr);
                  end
               end else if (room) begin
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= pack_word_addr(cur_bank, cur_addr);
               end
            end
            WAIT: begin
               if (line_start_i) begin
                  if (mem_valid_i) begin
                     state      <= (count_i == '0) ? IDLE : REQ;
                     mem_rd_q   <= (count_i != '0) && room;
                     mem_addr_q <= pack_word_addr(bank_i, new_addr);
                  end else begin
                     state <= FLUSH;
                  end
               end else if (mem_valid_i) begin
                  remaining <= remaining - CNT_W'(1);
                  cur_addr  <= next_addr;
                  if (push_last) begin
                     state <= IDLE;
                  end else begin
                     state      <= REQ;
                     mem_rd_q   <= room;
                     mem_addr_q <= pack_word_addr(cur_bank, next_addr);
                  end
               end
            end
            FLUSH: begin
               if (mem_valid_i) begin
                  state      <= (sel_count == '0) ? IDLE : REQ;
                  mem_rd_q   <= (sel_count != '0) && room;
                  mem_addr_q <= pack_word_addr(sel_bank, sel_addr);
               end
            end
            default: begin
               state    <= IDLE;
               mem_rd_q <= 1'b0;
            end
         endcase
      end
   end

   sync_fifo_flush #(
      .WIDTH (33),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_logic),
      .reset (reset),
      .flush (line_start_i),
      .push  (push),
      .din   ({push_last, mem_q_i}),
      .pop   (out_ready_i),
      .dout  (fifo_dout),
      .valid (fifo_valid),
      .count (fifo_count)
   );

   assign mem_rd_o    = mem_rd_q;
   assign mem_addr_o  = mem_addr_q;
   assign out_valid_o = fifo_valid;
   assign out_data_o  = fifo_dout[31:0];
   assign out_last_o  = fifo_dout[32];
   assign busy_o      = (state != IDLE) || fifo_valid;

endmodule

// File: tb/tb_video_line_fetcher.sv
module tb_video_line_fetcher;

   logic        clk_logic = 1'b0;
   logic        reset = 1'b1;
   logic        line_start_i = 1'b0;
   logic [15:0] base_addr_i = '0;
   logic        bank_i = 1'b0;
   logic [6:0]  count_i = '0;
   logic        mem_rd_o;
   logic [20:0] mem_addr_o;
   logic        mem_ready_i = 1'b0;
   logic        mem_valid_i = 1'b0;
   logic [31:0] mem_q_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] out_data_o;
   logic        out_last_o;
   logic        busy_o;

   video_line_fetcher dut (
      .clk_logic   (clk_logic),
      .reset       (reset),
      .line_start_i(line_start_i),
      .base_addr_i (base_addr_i),
      .bank_i      (bank_i),
      .count_i     (count_i),
      .mem_rd_o    (mem_rd_o),
      .mem_addr_o  (mem_addr_o),
      .mem_ready_i (mem_ready_i),
      .mem_valid_i (mem_valid_i),
      .mem_q_i     (mem_q_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .busy_o      (busy_o)
   );

   always #5 clk_logic = ~clk_logic;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [20:0] req_q[$];
   logic [32:0] out_q[$];
   int          ready_block = 0;
   int          hold_viol = 0;
   int          rd_high = 0;
   int          pend = 0;
   logic [20:0] pend_addr = '0;
   logic        prev_rd = 1'b0;
   logic        prev_acc = 1'b0;
   logic [20:0] prev_addr = '0;

   typedef struct {
      logic [15:0] base;
      logic        bank;
      logic [6:0]  count;
      logic [20:0] first;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [31:0] data_of(input logic [20:0] a);
      return {a[15:0] ^ 16'hC3C3, a[15:0]};
   endfunction

   function automatic logic [20:0] exp_addr(input logic [20:0] first, input int i);
      logic [14:0] w;
      w = first[14:0] + 15'(i);
      return {5'b0, first[15], w};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else
         pass_cnt++;
   endtask

   // SDRAM port model (data two cycles after accept) plus output collector.
   initial forever begin
      @(negedge clk_logic);
      #1;
      mem_valid_i = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            mem_valid_i = 1'b1;
            mem_q_i     = data_of(pend_addr);
         end
      end
      if (reset) begin
         prev_rd     = 1'b0;
         prev_acc    = 1'b0;
         mem_ready_i = 1'b0;
      end else begin
         if (prev_rd && !prev_acc && (!mem_rd_o || mem_addr_o != prev_addr))
            hold_viol++;
         if (mem_rd_o)
            rd_high++;
         if (mem_rd_o && ready_block > 0) begin
            mem_ready_i = 1'b0;
            ready_block--;
         end else begin
            mem_ready_i = 1'b1;
         end
         prev_rd   = mem_rd_o;
         prev_addr = mem_addr_o;
         prev_acc  = mem_rd_o && mem_ready_i;
         if (prev_acc) begin
            req_q.push_back(mem_addr_o);
            pend      = 2;
            pend_addr = mem_addr_o;
         end
         if (out_valid_o && out_ready_i)
            out_q.push_back({out_last_o, out_data_o});
      end
   end

   // Drives a one-cycle line start beginning at the current negedge.
   task automatic start_line(input logic [15:0] b, input logic bk, input logic [6:0] c);
      line_start_i = 1'b1;
      base_addr_i  = b;
      bank_i       = bk;
      count_i      = c;
      @(negedge clk_logic);
      line_start_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy_o || pend != 0) && n < 500) begin
         @(negedge clk_logic);
         n++;
      end
      repeat (3) @(negedge clk_logic);
      check({name, " finished"}, 64'(n < 500), 64'(1));
   endtask

   task automatic wait_reqs(input int want, input string name);
      int n;
      n = 0;
      while (req_q.size() < want && n < 200) begin
         @(negedge clk_logic);
         n++;
      end
      check({name, " request count reached"}, 64'(req_q.size()), 64'(want));
   endtask

   task automatic check_line(input string name, input logic [20:0] first, input int cnt);
      check({name, " requests"}, 64'(req_q.size()), 64'(cnt));
      check({name, " outputs"}, 64'(out_q.size()), 64'(cnt));
      for (int i = 0; i < cnt; i++) begin
         if (i < req_q.size())
            check($sformatf("%s addr[%0d]", name, i), 64'(req_q[i]), 64'(exp_addr(first, i)));
         if (i < out_q.size()) begin
            check($sformatf("%s data[%0d]", name, i), 64'(out_q[i][31:0]),
                  64'(data_of(exp_addr(first, i))));
            check($sformatf("%s last[%0d]", name, i), 64'(out_q[i][32]), 64'(i == cnt - 1));
         end
      end
   endtask

   task automatic clear_logs();
      req_q.delete();
      out_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{base: 16'h0400, bank: 1'b0, count: 7'd20, first: 21'h000200};
      vecs[1] = '{base: 16'hFFFC, bank: 1'b0, count: 7'd4,  first: 21'h007FFE};
      vecs[2] = '{base: 16'hFFFD, bank: 1'b1, count: 7'd3,  first: 21'h00FFFE};
      vecs[3] = '{base: 16'h1235, bank: 1'b1, count: 7'd1,  first: 21'h00891A};
      vecs[4] = '{base: 16'h0000, bank: 1'b0, count: 7'd0,  first: 21'h000000};
      vecs[5] = '{base: 16'h8000, bank: 1'b0, count: 7'd64, first: 21'h004000};

      out_ready_i = 1'b1;
      repeat (4) @(negedge clk_logic);
      check("reset mem_rd", 64'(mem_rd_o), 64'(0));
      check("reset mem_addr", 64'(mem_addr_o), 64'(0));
      check("reset out_valid", 64'(out_valid_o), 64'(0));
      check("reset out_data", 64'(out_data_o), 64'(0));
      check("reset out_last", 64'(out_last_o), 64'(0));
      check("reset busy", 64'(busy_o), 64'(0));
      reset = 1'b0;
      repeat (2) @(negedge clk_logic);

      for (int v = 0; v < 6; v++) begin
         clear_logs();
         start_line(vecs[v].base, vecs[v].bank, vecs[v].count);
         check($sformatf("vec%0d mem_rd after start", v), 64'(mem_rd_o), 64'(vecs[v].count != 0));
         check($sformatf("vec%0d busy after start", v), 64'(busy_o), 64'(vecs[v].count != 0));
         wait_idle($sformatf("vec%0d", v));
         check_line($sformatf("vec%0d", v), vecs[v].first, int'(vecs[v].count));
      end

      // request held for 5 cycles by the port
      clear_logs();
      rd_high = 0;
      ready_block = 5;
      start_line(16'h0800, 1'b0, 7'd1);
      wait_idle("hold");
      check("hold mem_rd high cycles", 64'(rd_high), 64'(6));
      check_line("hold", 21'h000400, 1);

      // backpressure: consumer stalled, FIFO fills after 8 words
      clear_logs();
      out_ready_i = 1'b0;
      start_line(16'h3000, 1'b0, 7'd12);
      repeat (60) @(negedge clk_logic);
      check("bp requests while stalled", 64'(req_q.size()), 64'(8));
      check("bp mem_rd while stalled", 64'(mem_rd_o), 64'(0));
      check("bp out_valid while stalled", 64'(out_valid_o), 64'(1));
      check("bp busy while stalled", 64'(busy_o), 64'(1));
      out_ready_i = 1'b1;
      wait_idle("bp");
      check_line("bp", 21'h001800, 12);

      // abort while waiting for data: line A dropped, line B fetched
      clear_logs();
      start_line(16'h2000, 1'b0, 7'd10);
      wait_reqs(4, "abortA");
      check("abortA words before abort", 64'(out_q.size()), 64'(3));
      for (int i = 0; i < 3; i++)
         if (i < out_q.size())
            check($sformatf("abortA data[%0d]", i), 64'(out_q[i][31:0]),
                  64'(data_of(exp_addr(21'h001000, i))));
      start_line(16'h4000, 1'b1, 7'd4);
      check("abort out_valid after flush", 64'(out_valid_o), 64'(0));
      clear_logs();
      wait_idle("abortB");
      check_line("abortB", 21'h00A000, 4);

      // abort while a request is still being held by the port
      clear_logs();
      ready_block = 3;
      start_line(16'h0100, 1'b0, 7'd5);
      start_line(16'h0600, 1'b0, 7'd2);
      wait_idle("abortreq");
      check("abortreq requests", 64'(req_q.size()), 64'(3));
      if (req_q.size() == 3) begin
         check("abortreq held addr", 64'(req_q[0]), 64'(21'h000080));
         check("abortreq new addr0", 64'(req_q[1]), 64'(21'h000300));
         check("abortreq new addr1", 64'(req_q[2]), 64'(21'h000301));
      end
      check("abortreq outputs", 64'(out_q.size()), 64'(2));
      for (int i = 0; i < 2; i++)
         if (i < out_q.size())
            check($sformatf("abortreq data[%0d]", i), 64'(out_q[i]),
                  64'({(i == 1), data_of(exp_addr(21'h000300, i))}));

      // line start coinciding with returning data: data dropped, new line at once
      clear_logs();
      start_line(16'h5000, 1'b0, 7'd6);
      wait_reqs(2, "coinc");
      @(negedge clk_logic);
      start_line(16'h6000, 1'b1, 7'd3);
      clear_logs();
      wait_idle("coincE");
      check_line("coincE", 21'h00B000, 3);

      // reset in the middle of a fetch
      clear_logs();
      start_line(16'h0400, 1'b0, 7'd3);
      wait_reqs(1, "rst");
      reset = 1'b1;
      @(negedge clk_logic);
      reset = 1'b0;
      check("rst mem_rd", 64'(mem_rd_o), 64'(0));
      check("rst mem_addr", 64'(mem_addr_o), 64'(0));
      check("rst out_valid", 64'(out_valid_o), 64'(0));
      check("rst out_last", 64'(out_last_o), 64'(0));
      check("rst busy", 64'(busy_o), 64'(0));
      repeat (8) @(negedge clk_logic);
      check("rst no output later", 64'(out_q.size()), 64'(0));
      check("rst no new request", 64'(req_q.size()), 64'(1));
      check("rst busy later", 64'(busy_o), 64'(0));

      check("request stability violations", 64'(hold_viol), 64'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
